// File: rtl/data_sync_hs.sv
// Destination-side CDC receiver: per-channel request synchronizer, bus capture on the
// detected event, valid/ready hold toward the consumer and toggle acknowledge to the source.
module data_sync_hs_ch #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int REQ_MODE   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_async,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  input  logic                 sync_ready,
  output logic                 ack_toggle,
  output logic                 err_drop
);
  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  logic [NUM_STAGES-1:0] sync_pipe;
  logic                  prev;
  logic                  last;
  logic                  evt;
  logic                  fire;
  state_t                state, state_nxt;
  logic [BUS_WIDTH-1:0]  data_nxt;
  logic                  ack_nxt, err_nxt;

  assign last = sync_pipe[NUM_STAGES-1];

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[NUM_STAGES-2:0], req_async};
      prev      <= last;
    end

  if (REQ_MODE == 0) begin : g_lvl
    // A level already high at reset release must not look like a rise: hold off
    // edge detection until both last and prev carry post-reset samples.
    logic [NUM_STAGES:0] arm_pipe;
    always_ff @(posedge CLK or negedge RST)
      if (!RST) arm_pipe <= '0;
      else      arm_pipe <= {arm_pipe[NUM_STAGES-1:0], 1'b1};
    assign evt = last & ~prev & arm_pipe[NUM_STAGES];
  end else begin : g_tgl
    assign evt = last ^ prev;
  end

  assign sync_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    data_nxt  = sync_bus;
    ack_nxt   = ack_toggle;
    err_nxt   = err_drop;
    fire      = (state == FULL) & sync_ready;
    unique case (state)
      IDLE: if (evt) begin
        state_nxt = FULL;
        data_nxt  = unsync_bus;
      end
      FULL: if (fire) begin
        ack_nxt = ~ack_toggle;
        // back-to-back: refill in the same cycle the consumer drains
        if (evt) data_nxt  = unsync_bus;
        else     state_nxt = IDLE;
      end else if (evt) begin
        err_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state      <= IDLE;
      sync_bus   <= '0;
      ack_toggle <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sync_bus   <= data_nxt;
      ack_toggle <= ack_nxt;
      err_drop   <= err_nxt;
    end
endmodule

module data_sync_hs #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_CH     = 2,
  parameter int REQ_MODE   = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH-1:0]           req_async,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           sync_valid,
  input  logic [NUM_CH-1:0]           sync_ready,
  output logic [NUM_CH-1:0]           ack_toggle,
  output logic [NUM_CH-1:0]           err_drop
);
  logic [NUM_CH-1:0][BUS_WIDTH-1:0] din, dout;

  assign din      = unsync_bus;
  assign sync_bus = dout;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    data_sync_hs_ch #(
      .NUM_STAGES(NUM_STAGES),
      .BUS_WIDTH (BUS_WIDTH),
      .REQ_MODE  (REQ_MODE)
    ) u_ch (
      .CLK       (CLK),
      .RST       (RST),
      .req_async (req_async[c]),
      .unsync_bus(din[c]),
      .sync_bus  (dout[c]),
      .sync_valid(sync_valid[c]),
      .sync_ready(sync_ready[c]),
      .ack_toggle(ack_toggle[c]),
      .err_drop  (err_drop[c])
    );
  end
endmodule

// File: tb/tb_data_sync_hs.sv
// Bench for data_sync_hs: a toggle-mode and a level-mode instance checked every cycle
// against a transfer-level model, plus directed scenarios with literal expectations.
module tb_data_sync_hs;
  localparam int N = 2, NCH = 2, W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  // index 0: toggle-mode DUT, index 1: level-mode DUT
  logic [NCH-1:0]   req [2];
  logic [NCH-1:0]   rdy [2];
  logic [NCH*W-1:0] ubus[2];
  logic [NCH*W-1:0] sbus[2];
  logic [NCH-1:0]   sval[2], ack[2], err[2];

  data_sync_hs #(.NUM_STAGES(N), .BUS_WIDTH(W), .NUM_CH(NCH), .REQ_MODE(1)) dut_t (
    .CLK(CLK), .RST(RST), .req_async(req[0]), .unsync_bus(ubus[0]), .sync_bus(sbus[0]),
    .sync_valid(sval[0]), .sync_ready(rdy[0]), .ack_toggle(ack[0]), .err_drop(err[0]));

  data_sync_hs #(.NUM_STAGES(N), .BUS_WIDTH(W), .NUM_CH(NCH), .REQ_MODE(0)) dut_l (
    .CLK(CLK), .RST(RST), .req_async(req[1]), .unsync_bus(ubus[1]), .sync_bus(sbus[1]),
    .sync_valid(sval[1]), .sync_ready(rdy[1]), .ack_toggle(ack[1]), .err_drop(err[1]));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Model: an event at edge t is decided by the request as sampled N and N+1 edges
  // earlier. Samples from before reset count as 0 (toggle) or as high (level, so a
  // request already high is not a rise).
  int               cyc;
  logic [NCH-1:0]   hist[2][8];
  logic [NCH-1:0]   mv[2], mack[2], merr[2];
  logic [W-1:0]     md[2][NCH];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 8; i++) hist[d][i] = (d == 1) ? '1 : '0;
        mv[d] = '0; mack[d] = '0; merr[d] = '0;
        for (int c = 0; c < NCH; c++) md[d][c] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        hist[d][cyc % 8] = req[d];
        for (int c = 0; c < NCH; c++) begin
          logic a, b, ev;
          a  = hist[d][(cyc - N + 8) % 8][c];
          b  = hist[d][(cyc - N - 1 + 8) % 8][c];
          ev = (d == 0) ? (a ^ b) : (a & ~b);
          if (!mv[d][c]) begin
            if (ev) begin mv[d][c] = 1'b1; md[d][c] = ubus[d][c*W +: W]; end
          end else if (rdy[d][c]) begin
            mack[d][c] = ~mack[d][c];
            if (ev) md[d][c] = ubus[d][c*W +: W];
            else    mv[d][c] = 1'b0;
          end else if (ev) begin
            merr[d][c] = 1'b1;
          end
        end
      end
      cyc++;
    end
  end

  always @(negedge CLK)
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++)
        chk($sformatf("cycle_d%0d_ch%0d", d, c),
            32'({sval[d][c], ack[d][c], err[d][c], sbus[d][c*W +: W]}),
            32'({mv[d][c], mack[d][c], merr[d][c], md[d][c]}));

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_d%0d", nm, d), 32'({sval[d], ack[d], err[d], sbus[d]}), 32'd0);
  endtask

  int caps;

  initial begin
    for (int d = 0; d < 2; d++) begin req[d] = '0; rdy[d] = '0; ubus[d] = '0; end
    step(3);
    chk_all_zero("reset");
    RST = 1'b1;
    step(3);

    // single toggle on ch0, ready high
    rdy[0] = 2'b11;
    ubus[0][7:0] = 8'hA5;
    req[0][0] = ~req[0][0];
    step(3);
    chk("s1_valid", 32'(sval[0][0]), 32'd1);
    chk("s1_bus",   32'(sbus[0][7:0]), 32'hA5);
    chk("s1_ack0",  32'(ack[0][0]), 32'd0);
    step(1);
    chk("s1_ack1",  32'(ack[0][0]), 32'd1);
    chk("s1_idle",  32'(sval[0][0]), 32'd0);

    // backpressure on ch0
    rdy[0][0] = 1'b0;
    ubus[0][7:0] = 8'h3C;
    req[0][0] = ~req[0][0];
    step(3);
    chk("bp_cap", 32'({sval[0][0], sbus[0][7:0]}), 32'h13C);
    step(10);
    chk("bp_hold", 32'({sval[0][0], ack[0][0], sbus[0][7:0]}), 32'h33C);
    rdy[0][0] = 1'b1;
    step(1);
    chk("bp_ack", 32'({sval[0][0], ack[0][0]}), 32'd0);
    step(3);
    chk("bp_once", 32'(ack[0][0]), 32'd0);

    // simultaneous fire and event on ch1
    rdy[0][1] = 1'b0;
    ubus[0][15:8] = 8'h11;
    req[0][1] = ~req[0][1];
    step(3);
    chk("sim_full", 32'({sval[0][1], sbus[0][15:8]}), 32'h111);
    ubus[0][15:8] = 8'h22;
    req[0][1] = ~req[0][1];
    step(2);
    chk("sim_pre", 32'({sval[0][1], ack[0][1], sbus[0][15:8]}), 32'h211);
    rdy[0][1] = 1'b1;
    step(1);
    chk("sim_swap", 32'({sval[0][1], ack[0][1], sbus[0][15:8]}), 32'h322);
    rdy[0][1] = 1'b0;
    step(1);
    chk("sim_hold", 32'({sval[0][1], ack[0][1], sbus[0][15:8]}), 32'h322);

    // drop on ch0
    rdy[0][0] = 1'b0;
    ubus[0][7:0] = 8'h55;
    req[0][0] = ~req[0][0];
    step(3);
    chk("drop_cap", 32'({sval[0][0], err[0][0], sbus[0][7:0]}), 32'h255);
    ubus[0][7:0] = 8'h77;
    req[0][0] = ~req[0][0];
    step(3);
    chk("drop_err", 32'({sval[0][0], err[0][0], sbus[0][7:0]}), 32'h355);
    chk("drop_ch1", 32'({err[0][1], sbus[0][15:8]}), 32'h022);
    step(2);
    rdy[0][0] = 1'b1;
    step(1);
    chk("drop_sticky", 32'({sval[0][0], err[0][0]}), 32'd1);

    // level mode: high 5, low 5, high 5 -> two captures
    rdy[1] = 2'b11;
    ubus[1][7:0] = 8'h5A;
    caps = 0;
    for (int i = 0; i < 25; i++) begin
      req[1][0] = (i < 5) || (i >= 10 && i < 15);
      step(1);
      if (sval[1][0]) caps++;
    end
    chk("lvl_caps", 32'(caps), 32'd2);

    // reset mid-transfer, released with level request already high
    rdy[1][0] = 1'b0;
    ubus[1][7:0] = 8'hC3;
    req[1][0] = 1'b1;
    step(3);
    chk("rst_full", 32'({sval[1][0], sbus[1][7:0]}), 32'h1C3);
    #2 RST = 1'b0;
    #1 chk_all_zero("rst_async");
    req[0] = '0;
    step(2);
    RST = 1'b1;
    step(10);
    chk("rst_nocap", 32'(sval[1][0]), 32'd0);
    req[1][0] = 1'b0;
    step(3);
    req[1][0] = 1'b1;
    step(3);
    chk("rst_recap", 32'({sval[1][0], sbus[1][7:0]}), 32'h1C3);

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        rdy[d]  = NCH'($urandom);
        ubus[d] = (NCH*W)'($urandom);
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(3) == 0) req[d][c] = ~req[d][c];
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_sync_hs.md
# data_sync_hs

Multi-channel, parametrised successor to our single-bus enable-pulse synchronizer. It lives on the destination side of a clock-domain crossing. For each channel it synchronizes an asynchronous request (level or toggle) and captures the quasi-static source bus on the detected event. It then holds the word with a valid/ready handshake toward the consumer and returns a toggle acknowledge to the source domain, so the source can issue back-to-back transfers without losing data.

## Interface
- NUM_STAGES, 2, synchronizer flops per request line; legal values are 2 and above.
- BUS_WIDTH, 8, data width per channel.
- NUM_CH, 2, number of independent channels.
- REQ_MODE, 1, request encoding: 0 = level (a rising edge is an event); 1 = toggle (any edge is an event).
- CLK  in  1  destination clock.
- RST  in  1  reset, asynchronous, active-low.
- req_async  in  NUM_CH  asynchronous per-channel request.
- unsync_bus  in  NUM_CH*BUS_WIDTH  source data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH]; stable while its request is outstanding.
- sync_bus  out  NUM_CH*BUS_WIDTH  captured data, same packing.
- sync_valid  out  NUM_CH  per-channel data-valid.
- sync_ready  in  NUM_CH  per-channel consumer ready.
- ack_toggle  out  NUM_CH  per-channel acknowledge; flips once per completed transfer; synchronized by the source domain.
- err_drop  out  NUM_CH  sticky per-channel flag: an event was dropped.

## Operation
- Reset: all synchronizer flops, edge-detect flops, sync_bus, sync_valid, ack_toggle and err_drop are 0.
- In toggle mode, the source must also reset its request to 0.
- Each channel is fully independent. There is no arbitration and no shared state.
- Per channel:
  - sync chain shifts req_async[c] through NUM_STAGES flops.
  - prev flop holds the last stage delayed by one cycle.
  - event = last & ~prev (REQ_MODE 0) or last ^ prev (REQ_MODE 1).
  - fire = sync_valid & sync_ready.
- Two-state FSM per channel: IDLE (sync_valid=0) and FULL (sync_valid=1).
  - IDLE, event: capture unsync_bus slice into sync_bus, go to FULL.
  - IDLE, no event: hold.
  - FULL, fire, no event: flip ack_toggle, go to IDLE; sync_bus holds its last value.
  - FULL, fire and event in the same cycle: flip ack_toggle, capture new data, stay FULL (sync_valid remains 1). No bubble and no loss.
  - FULL, event without fire: drop the event, set err_drop (sticky until reset), keep old data, no ack change.
  - FULL, neither: hold data and valid. sync_bus must not change while sync_valid=1.
- ack_toggle changes only on fire.
- sync_ready is ignored while sync_valid=0.
- Reset mid-transfer returns the channel to IDLE immediately and clears data and valid. After reset, req_async that is already high (level mode) is not an event until it is seen to rise.

## Timing
- Let req_async change before CLK edge k.
- sync_valid and sync_bus update on edge k+NUM_STAGES, giving a latency of NUM_STAGES cycles.
- No combinational path from any input to any output; all outputs are registered.
- Fire is sampled at edge t:
  - ack_toggle flips at edge t.
  - sync_valid falls at edge t, unless a simultaneous event occurs.
- Sustained throughput per channel is bounded by the source round trip. The destination alone can accept one word per cycle if events arrive every cycle with ready held high.
- err_drop asserts on the same edge the dropped event would have captured.

## Test plan
- Reset, single toggle: NUM_STAGES=2, REQ_MODE=1, ch0.
  - Stimulus: unsync_bus=0xA5, toggle req at edge 0, sync_ready=1.
  - Response: sync_valid=1 with sync_bus=0xA5 after edge 2; ack_toggle 0→1 at edge 3; sync_valid=0 after edge 3.
- Backpressure: sync_ready=0 for 10 cycles after capture of 0x3C.
  - Response: sync_valid and 0x3C hold, ack stays unchanged.
  - Then raise ready: ack flips exactly once.
- Simultaneous fire and event: ch1 FULL with 0x11, new toggle event (data 0x22) synced on the same edge as ready=1.
  - Response: sync_valid stays 1, sync_bus becomes 0x22, ack flips once.
- Drop: ch0 FULL, ready=0, second event (data 0x77).
  - Response: err_drop[0]=1 and sticky; sync_bus stays at the old value; ch1 unaffected.
- Level mode: REQ_MODE=0.
  - Stimulus: req held high for 5 cycles, then low, then high again.
  - Response: exactly two captures; no event on the falling edge.
- Reset mid-transfer: assert RST while FULL.
  - Response: all outputs 0 asynchronously.
  - Stimulus: release with req already high in level mode.
  - Response: no capture until the next rising edge.
